// File: rtl/addsub_pkg.sv
// Shared types and constants for the multi-cycle adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = w_carry[CHUNK];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit add/sub: one CHUNK-bit slice per RUN cycle through a
// single reused ripple adder, with valid/ready handshakes on both sides.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_flag_c;
  logic             r_flag_v;
  logic             r_flag_z;
  logic             r_flag_n;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_result_next;
  logic             w_last;

  assign w_last = (r_cnt == LAST_CNT);

  // Constant-index slice mux keeps the chunk select free of variable part-selects.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_chunk = r_a[i*CHUNK +: CHUNK];
        w_b_chunk = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (w_a_chunk),
    .b    (w_b_chunk),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Full result as it will look after this cycle, so flags see the final chunk.
  always_comb begin
    w_result_next = r_result;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_result_next[i*CHUNK +: CHUNK] = w_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction becomes A + ~B + 1: invert B here, seed the carry with 1.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= (sub == OP_SUB);
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_result <= w_result_next;
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_flag_c <= w_cout;
            r_flag_v <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                        (w_result_next[WIDTH-1] != r_a[WIDTH-1]);
            r_flag_z <= (w_result_next == '0);
            r_flag_n <= w_result_next[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign flag_c    = r_flag_c;
  assign flag_v    = r_flag_v;
  assign flag_z    = r_flag_z;
  assign flag_n    = r_flag_n;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: three instances (CHUNK = 1, 8, 32 at WIDTH = 32)
// checked against an arithmetic A +/- B reference model.
module tb_addsub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [2:0]  irdy;
  logic [2:0]  ov;
  logic [2:0]  fc;
  logic [2:0]  fv;
  logic [2:0]  fz;
  logic [2:0]  fn;
  logic [31:0] res [3];

  int n_checks = 0;
  int n_fail   = 0;
  int chunk_of [3] = '{1, 8, 32};

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]),
    .flag_c(fc[0]), .flag_v(fv[0]), .flag_z(fz[0]), .flag_n(fn[0])
  );

  addsub_seq #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]),
    .flag_c(fc[1]), .flag_v(fv[1]), .flag_z(fz[1]), .flag_n(fn[1])
  );

  addsub_seq #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[2]), .out_ready(ordy[2]), .result(res[2]),
    .flag_c(fc[2]), .flag_v(fv[2]), .flag_z(fz[2]), .flag_n(fn[2])
  );

  // Reference: {result, c, v, z, n} from plain unsigned/signed arithmetic.
  function automatic logic [35:0] model(input logic [31:0] xa, input logic [31:0] xb,
                                        input logic xs);
    longint      sa = longint'($signed(xa));
    longint      sb = longint'($signed(xb));
    longint      sr;
    logic [32:0] u;
    logic [31:0] r;
    logic        c;
    logic        v;
    if (!xs) begin
      u  = {1'b0, xa} + {1'b0, xb};
      r  = u[31:0];
      c  = u[32];
      sr = sa + sb;
    end else begin
      r  = xa - xb;
      c  = (xa >= xb);
      sr = sa - sb;
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {r, c, v, (r == 32'd0), r[31]};
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    if ($urandom_range(0, 7) == 0) return specials[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  // Issue one operation on instance k; returns latency (cycle index of first
  // out_valid, accept = cycle 0), result and flags {c,v,z,n}.
  task automatic do_op(input int k, input logic [31:0] xa, input logic [31:0] xb,
                       input logic xs, input bit hold, output int lat,
                       output logic [31:0] r, output logic [3:0] f);
    int t = 0;
    @(negedge clk);
    while (!irdy[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (!irdy[k]) begin
      n_fail++;
      $display("FAIL in_ready_timeout inst=%0d: in_ready=%0b required 1", k, irdy[k]);
    end
    a = xa; b = xb; sub = xs; iv[k] = 1'b1;
    @(posedge clk);
    #1 iv[k] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!ov[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (!ov[k]) begin
      n_fail++;
      $display("FAIL out_valid_timeout inst=%0d: out_valid=%0b required 1", k, ov[k]);
    end
    r = res[k];
    f = {fc[k], fv[k], fz[k], fn[k]};
    $display("op inst=%0d chunk=%0d %h %s %h -> %h cvzn=%b lat=%0d",
             k, chunk_of[k], xa, xs ? "-" : "+", xb, r, f, lat);
    if (!hold) begin
      ordy[k] = 1'b1;
      @(posedge clk);
      #1 ordy[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = '0; ordy = '0; a = '0; b = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ov[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out_valid inst=%0d: got %b required 0", k, ov[k]);
      end
      n_checks++;
      if (res[k] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_result inst=%0d: got %h required 0", k, res[k]);
      end
      n_checks++;
      if ({fc[k], fv[k], fz[k], fn[k]} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_flags inst=%0d: got %b required 0000", k,
                 {fc[k], fv[k], fz[k], fn[k]});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (irdy !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 111", irdy);
    end
  endtask

  task automatic test_directed();
    logic [31:0] xa [4] = '{32'h0000_0005, 32'h0000_0005, 32'h7FFF_FFFF, 32'h0000_0000};
    logic [31:0] xb [4] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 32'h0000_0001};
    logic        xs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] er [4] = '{32'h0000_0008, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [3:0]  ef [4] = '{4'b0000, 4'b1010, 4'b0101, 4'b0001};
    int          lat;
    logic [31:0] r;
    logic [3:0]  f;
    for (int i = 0; i < 4; i++) begin
      do_op(1, xa[i], xb[i], xs[i], 1'b0, lat, r, f);
      n_checks++;
      if (r !== er[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got %h required %h", i, r, er[i]);
      end
      n_checks++;
      if (f !== ef[i]) begin
        n_fail++;
        $display("FAIL directed_flags[%0d]: got cvzn=%b required %b", i, f, ef[i]);
      end
      n_checks++;
      if (lat != 5) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d required 5", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] r;
    logic [3:0]  f;
    do_op(1, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b1, lat, r, f);
    n_checks++;
    if ({r, f} !== {32'h0100_0000, 4'b0000}) begin
      n_fail++;
      $display("FAIL bp_first: got %h cvzn=%b required 01000000 0000", r, f);
    end
    a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; iv[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({ov[1], irdy[1], res[1]} !== {1'b1, 1'b0, 32'h0100_0000}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b res=%h required ov=1 ir=0 res=01000000",
                 i, ov[1], irdy[1], res[1]);
      end
    end
    ordy[1] = 1'b1;
    @(posedge clk);
    #1 ordy[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ov[1], irdy[1]} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_idle: got ov=%b ir=%b required ov=0 ir=1", ov[1], irdy[1]);
    end
    @(posedge clk);
    #1 iv[1] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!ov[1] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    $display("op inst=1 chunk=8 11111111 + 22222222 -> %h lat=%0d", res[1], lat);
    n_checks++;
    if (res[1] !== 32'h3333_3333 || lat != 5) begin
      n_fail++;
      $display("FAIL bp_second: got res=%h lat=%0d required 33333333 lat=5", res[1], lat);
    end
    ordy[1] = 1'b1;
    @(posedge clk);
    #1 ordy[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int          t = 0;
    bit          stale = 1'b0;
    int          lat;
    logic [31:0] r;
    logic [3:0]  f;
    @(negedge clk);
    while (!irdy[1] && t < 100) begin
      @(negedge clk);
      t++;
    end
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; iv[1] = 1'b1;
    @(posedge clk);
    #1 iv[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ov[1], irdy[1], res[1], fc[1], fv[1], fz[1], fn[1]} !== {2'b01, 32'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL mid_reset: got ov=%b ir=%b res=%h cvzn=%b required ov=0 ir=1 res=0 0000",
               ov[1], irdy[1], res[1], {fc[1], fv[1], fz[1], fn[1]});
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov[1]) stale = 1'b1;
    end
    n_checks++;
    if (stale) begin
      n_fail++;
      $display("FAIL mid_reset_stale: got out_valid=1 after reset required 0");
    end
    do_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, r, f);
    n_checks++;
    if ({r, f} !== {32'h0000_0000, 4'b1010}) begin
      n_fail++;
      $display("FAIL mid_reset_next: got %h cvzn=%b required 00000000 1010", r, f);
    end
  endtask

  task automatic test_latency_sweep();
    int          lat;
    logic [31:0] r;
    logic [3:0]  f;
    logic [31:0] xa;
    logic [31:0] xb;
    logic        xs;
    logic [35:0] exp_v;
    for (int k = 0; k < 3; k++) begin
      xa = $urandom; xb = $urandom; xs = 1'($urandom_range(0, 1));
      exp_v = model(xa, xb, xs);
      do_op(k, xa, xb, xs, 1'b0, lat, r, f);
      n_checks++;
      if (lat != 32 / chunk_of[k] + 1) begin
        n_fail++;
        $display("FAIL sweep_latency chunk=%0d: got %0d required %0d",
                 chunk_of[k], lat, 32 / chunk_of[k] + 1);
      end
      n_checks++;
      if ({r, f} !== exp_v) begin
        n_fail++;
        $display("FAIL sweep_value chunk=%0d: got %h/%b required %h/%b",
                 chunk_of[k], r, f, exp_v[35:4], exp_v[3:0]);
      end
    end
  endtask

  task automatic test_random();
    int          lat;
    logic [31:0] r;
    logic [3:0]  f;
    logic [31:0] xa;
    logic [31:0] xb;
    logic        xs;
    logic [35:0] exp_v;
    for (int i = 0; i < 1000; i++) begin
      xa = pick_operand(); xb = pick_operand(); xs = 1'($urandom_range(0, 1));
      exp_v = model(xa, xb, xs);
      do_op(i % 3, xa, xb, xs, 1'b0, lat, r, f);
      n_checks++;
      if ({r, f} !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d] chunk=%0d %h %s %h: got %h/%b required %h/%b",
                 i, chunk_of[i % 3], xa, xs ? "-" : "+", xb, r, f, exp_v[35:4], exp_v[3:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_latency_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
